// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the single-ported R/I/J datapath.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB, shares the one
// memory port between instruction fetch and load/store, counts retired
// instructions and halts on a halt instruction or a memory-ack timeout.
//
// Memory handshake: mem_req is held high for every FETCH/MEM cycle; the
// request completes in the first cycle where mem_req and mem_ack are both 1.
// mem_ack in any other state carries no meaning and is ignored. If the ack
// does not arrive within MEM_TIMEOUT cycles the request is dropped (mem_req
// low in that final cycle) and the sequencer parks in HALT.
module multicycle_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [6:0]       ins_class,
  input  logic             alu_zero,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_is_fetch,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             alu_en,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             halted,
  output logic             timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  // Wait counter only has to reach MEM_TIMEOUT-1.
  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT =
    WAIT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);
  localparam bit TIMEOUT_EN = (MEM_TIMEOUT != 0);

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]   retired_q;
  logic               halted_q, timeout_q;
  logic               retire, tmo_hit, at_limit;
  logic               is_nop, is_j, is_ld, is_st, is_cond, is_r, is_i;

  // One-hot class after priority: nop > J > ld > st > cond > R > I.
  always_comb begin
    is_nop  = 1'b0;
    is_j    = 1'b0;
    is_ld   = 1'b0;
    is_st   = 1'b0;
    is_cond = 1'b0;
    is_r    = 1'b0;
    is_i    = 1'b0;
    if (ins_class[6])      is_nop  = 1'b1;
    else if (ins_class[3]) is_j    = 1'b1;
    else if (ins_class[2]) is_ld   = 1'b1;
    else if (ins_class[1]) is_st   = 1'b1;
    else if (ins_class[0]) is_cond = 1'b1;
    else if (ins_class[5]) is_r    = 1'b1;
    else if (ins_class[4]) is_i    = 1'b1;
  end

  assign at_limit = TIMEOUT_EN && (wait_cnt == WAIT_LIMIT);

  // Next-state and strobe decode; every strobe defaults low.
  always_comb begin
    state_d      = state_q;
    retire       = 1'b0;
    tmo_hit      = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_is_fetch = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 2'b00;
    alu_en       = 1'b0;
    reg_we       = 1'b0;
    wb_sel       = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ack) begin
          mem_req      = 1'b1;
          mem_is_fetch = 1'b1;
          ir_we        = 1'b1;
          pc_we        = 1'b1;
          state_d      = S_DECODE;
        end else if (at_limit) begin
          tmo_hit = 1'b1;
          state_d = S_HALT;
        end else begin
          mem_req      = 1'b1;
          mem_is_fetch = 1'b1;
        end
      end
      S_DECODE: begin
        if (is_nop) begin
          state_d = S_HALT;
        end else if (is_j) begin
          pc_we  = 1'b1;
          pc_src = 2'b10;
          retire = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_en = 1'b1;
        if (is_ld || is_st) begin
          state_d = S_MEM;
        end else if (is_cond) begin
          pc_we  = alu_zero;
          pc_src = 2'b01;
          retire = 1'b1;
        end else if (is_r || is_i) begin
          state_d = S_WB;
        end else begin
          retire = 1'b1;
        end
      end
      S_MEM: begin
        if (mem_ack) begin
          mem_req = 1'b1;
          mem_we  = is_st;
          if (is_ld) state_d = S_WB;
          else       retire  = 1'b1;
        end else if (at_limit) begin
          tmo_hit = 1'b1;
          state_d = S_HALT;
        end else begin
          mem_req = 1'b1;
          mem_we  = is_st;
        end
      end
      S_WB: begin
        reg_we = 1'b1;
        wb_sel = is_ld ? 2'b01 : 2'b00;
        retire = 1'b1;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (retire) state_d = run ? S_FETCH : S_IDLE;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Wait counter: counts un-acked FETCH/MEM cycles, cleared everywhere else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wait_cnt <= '0;
    else if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ack)
      wait_cnt <= wait_cnt + 1'b1;
    else
      wait_cnt <= '0;
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         retired_q <= '0;
    else if (retire) retired_q <= retired_q + 1'b1;
  end

  // Sticky halt and timeout flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (state_d == S_HALT) halted_q  <= 1'b1;
      if (tmo_hit)           timeout_q <= 1'b1;
    end
  end

  assign state       = state_q;
  assign retired     = retired_q;
  assign halted      = halted_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed scenarios plus a randomized
// instruction stream, each instruction expanded into its expected phase list.
module tb_multicycle_ctrl;

  localparam int CNT_W       = 8;
  localparam int MEM_TIMEOUT = 4;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                         ST_EXEC = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5,
                         ST_HALT = 3'd6;

  // {mem_req, mem_we, mem_is_fetch, ir_we, pc_we, pc_src, alu_en, reg_we, wb_sel}
  localparam logic [10:0] B_NONE   = 11'b0_0_0_0_0_00_0_0_00;
  localparam logic [10:0] B_FWAIT  = 11'b1_0_1_0_0_00_0_0_00;
  localparam logic [10:0] B_FACK   = 11'b1_0_1_1_1_00_0_0_00;
  localparam logic [10:0] B_JUMP   = 11'b0_0_0_0_1_10_0_0_00;
  localparam logic [10:0] B_EXEC   = 11'b0_0_0_0_0_00_1_0_00;
  localparam logic [10:0] B_BR_T   = 11'b0_0_0_0_1_01_1_0_00;
  localparam logic [10:0] B_BR_N   = 11'b0_0_0_0_0_01_1_0_00;
  localparam logic [10:0] B_MEM_LD = 11'b1_0_0_0_0_00_0_0_00;
  localparam logic [10:0] B_MEM_ST = 11'b1_1_0_0_0_00_0_0_00;
  localparam logic [10:0] B_WB_ALU = 11'b0_0_0_0_0_00_0_1_00;
  localparam logic [10:0] B_WB_LD  = 11'b0_0_0_0_0_00_0_1_01;

  localparam int K_R = 0, K_I = 1, K_J = 2, K_LD = 3, K_ST = 4, K_BR = 5,
                 K_ILL = 6, K_NOP = 7;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             run = 1'b0;
  logic [6:0]       ins_class = '0;
  logic             alu_zero = 1'b0;
  logic             mem_ack = 1'b0;
  logic             mem_req, mem_we, mem_is_fetch, ir_we, pc_we, alu_en, reg_we;
  logic [1:0]       pc_src, wb_sel;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired;
  logic             halted, timeout_err;
  logic [10:0]      strb;

  assign strb = {mem_req, mem_we, mem_is_fetch, ir_we, pc_we, pc_src,
                 alu_en, reg_we, wb_sel};

  multicycle_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .run(run), .ins_class(ins_class),
    .alu_zero(alu_zero), .mem_ack(mem_ack), .mem_req(mem_req),
    .mem_we(mem_we), .mem_is_fetch(mem_is_fetch), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .alu_en(alu_en), .reg_we(reg_we),
    .wb_sel(wb_sel), .state(state), .retired(retired), .halted(halted),
    .timeout_err(timeout_err)
  );

  // scoreboard: one entry per expected clock cycle
  typedef struct packed {
    logic [6:0]  cls;
    logic        z;
    logic        retire;
    logic        run;
    logic        ack;
    logic [2:0]  st;
    logic [10:0] strb;
  } step_t;

  step_t            exp_q[$];
  logic [CNT_W-1:0] exp_ret;
  int               checks = 0;
  int               errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rb();
    return ($urandom_range(0, 1) == 1);
  endfunction

  // Base flags plus a mask of flags that rank below the instruction's own class.
  function automatic logic [6:0] class_of(input int kind, input logic mix);
    logic [6:0] base, low;
    base = '0;
    low  = '0;
    case (kind)
      K_R:   begin base = 7'b0100000; low = 7'b0010000; end
      K_I:   begin base = 7'b0010000; low = 7'b0000000; end
      K_J:   begin base = 7'b0001000; low = 7'b0110111; end
      K_LD:  begin base = 7'b0010100; low = 7'b0110011; end
      K_ST:  begin base = 7'b0010010; low = 7'b0110001; end
      K_BR:  begin base = 7'b0010001; low = 7'b0110000; end
      K_NOP: begin base = 7'b1000000; low = 7'b0111111; end
      default: begin base = 7'b0000000; low = 7'b0000000; end
    endcase
    if (mix) return base | (low & 7'($urandom_range(0, 127)));
    return base;
  endfunction

  task automatic push_step(input logic [6:0] c, input logic z, input logic ret,
                           input logic r, input logic a, input logic [2:0] s,
                           input logic [10:0] b);
    step_t e;
    e.cls = c; e.z = z; e.retire = ret; e.run = r; e.ack = a; e.st = s; e.strb = b;
    exp_q.push_back(e);
  endtask

  // Expand one instruction into its phase list.
  task automatic push_instr(input int kind, input logic z, input int fw, input int mw,
                            input logic run_end, input logic from_idle, input logic mix);
    logic [6:0] c;
    c = class_of(kind, mix);
    if (from_idle) push_step(c, z, 1'b0, 1'b1, rb(), ST_IDLE, B_NONE);
    for (int i = 0; i < fw; i++) push_step(c, z, 1'b0, rb(), 1'b0, ST_FETCH, B_FWAIT);
    push_step(c, z, 1'b0, rb(), 1'b1, ST_FETCH, B_FACK);
    case (kind)
      K_NOP: push_step(c, z, 1'b0, rb(), rb(), ST_DECODE, B_NONE);
      K_J:   push_step(c, z, 1'b1, run_end, rb(), ST_DECODE, B_JUMP);
      default: begin
        push_step(c, z, 1'b0, rb(), rb(), ST_DECODE, B_NONE);
        case (kind)
          K_BR:  push_step(c, z, 1'b1, run_end, rb(), ST_EXEC, z ? B_BR_T : B_BR_N);
          K_ILL: push_step(c, z, 1'b1, run_end, rb(), ST_EXEC, B_EXEC);
          K_R, K_I: begin
            push_step(c, z, 1'b0, rb(), rb(), ST_EXEC, B_EXEC);
            push_step(c, z, 1'b1, run_end, rb(), ST_WB, B_WB_ALU);
          end
          K_ST: begin
            push_step(c, z, 1'b0, rb(), rb(), ST_EXEC, B_EXEC);
            for (int i = 0; i < mw; i++) push_step(c, z, 1'b0, rb(), 1'b0, ST_MEM, B_MEM_ST);
            push_step(c, z, 1'b1, run_end, 1'b1, ST_MEM, B_MEM_ST);
          end
          default: begin
            push_step(c, z, 1'b0, rb(), rb(), ST_EXEC, B_EXEC);
            for (int i = 0; i < mw; i++) push_step(c, z, 1'b0, rb(), 1'b0, ST_MEM, B_MEM_LD);
            push_step(c, z, 1'b0, rb(), 1'b1, ST_MEM, B_MEM_LD);
            push_step(c, z, 1'b1, run_end, rb(), ST_WB, B_WB_LD);
          end
        endcase
      end
    endcase
  endtask

  // Drive and check up to n queued cycles (n < 0 = all).
  task automatic play(input int n);
    step_t e;
    int    done;
    done = 0;
    while (exp_q.size() > 0 && (n < 0 || done < n)) begin
      e = exp_q.pop_front();
      run = e.run; ins_class = e.cls; alu_zero = e.z; mem_ack = e.ack;
      @(negedge clk);
      check("state", 32'(state), 32'(e.st));
      check("strobes", 32'(strb), 32'(e.strb));
      check("retired", 32'(retired), 32'(exp_ret));
      check("flags", 32'({halted, timeout_err}), 32'(2'b00));
      @(posedge clk); #1;
      if (e.retire) exp_ret = exp_ret + 1'b1;
      done++;
    end
  endtask

  task automatic check_halt(input int n, input logic tmo);
    for (int i = 0; i < n; i++) begin
      run = 1'b1; mem_ack = rb(); ins_class = 7'($urandom_range(0, 127));
      @(negedge clk);
      check("halt_state", 32'(state), 32'(ST_HALT));
      check("halt_strobes", 32'(strb), 32'(B_NONE));
      check("halt_flags", 32'({halted, timeout_err}), 32'({1'b1, tmo}));
      check("halt_retired", 32'(retired), 32'(exp_ret));
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; mem_ack = 1'b0; ins_class = '0; alu_zero = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    exp_ret = '0;
  endtask

  initial begin
    logic prev_run;
    int   kind;
    exp_ret = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // idle with run low: nothing moves regardless of other inputs
    for (int i = 0; i < 10; i++) push_step(7'($urandom_range(0, 127)), rb(), 1'b0, 1'b0,
                                           rb(), ST_IDLE, B_NONE);
    play(-1);

    // three back-to-back R-type, zero wait
    push_instr(K_R, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
    push_instr(K_R, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    push_instr(K_R, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    play(-1);
    check("r3_retired", 32'(retired), 32'd3);

    // lw with two MEM waits, sw, both branch outcomes, jump, illegal, I-type
    push_instr(K_LD,  1'b0, 0, 2, 1'b1, 1'b1, 1'b0);
    push_instr(K_ST,  1'b0, 1, 0, 1'b1, 1'b0, 1'b0);
    push_instr(K_BR,  1'b1, 0, 0, 1'b1, 1'b0, 1'b0);
    push_instr(K_BR,  1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    push_instr(K_J,   1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    push_instr(K_ILL, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    push_instr(K_I,   1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    play(-1);
    check("mix_retired", 32'(retired), 32'd10);

    // ack arriving on the last allowed cycle of FETCH and MEM completes normally
    push_instr(K_LD, 1'b0, MEM_TIMEOUT - 1, MEM_TIMEOUT - 1, 1'b0, 1'b1, 1'b0);
    play(-1);
    check("limit_retired", 32'(retired), 32'd11);

    // async reset in the middle of a waiting MEM access
    push_instr(K_ST, 1'b0, 0, 2, 1'b1, 1'b1, 1'b0);
    play(5);
    #2 rst = 1'b1;
    #1;
    check("rst_state", 32'(state), 32'(ST_IDLE));
    check("rst_strobes", 32'(strb), 32'(B_NONE));
    check("rst_retired", 32'(retired), 32'd0);
    check("rst_flags", 32'({halted, timeout_err}), 32'd0);
    do_reset();

    // FETCH timeout: ack never comes
    push_step(7'b0100000, 1'b0, 1'b0, 1'b1, 1'b0, ST_IDLE, B_NONE);
    for (int i = 0; i < MEM_TIMEOUT - 1; i++)
      push_step(7'b0100000, 1'b0, 1'b0, 1'b1, 1'b0, ST_FETCH, B_FWAIT);
    push_step(7'b0100000, 1'b0, 1'b0, 1'b1, 1'b0, ST_FETCH, B_NONE);
    play(-1);
    check_halt(5, 1'b1);

    // MEM timeout on a store after one retired instruction
    do_reset();
    push_instr(K_R, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
    push_step(7'b0010010, 1'b0, 1'b0, 1'b1, 1'b1, ST_FETCH, B_FACK);
    push_step(7'b0010010, 1'b0, 1'b0, 1'b1, 1'b0, ST_DECODE, B_NONE);
    push_step(7'b0010010, 1'b0, 1'b0, 1'b1, 1'b0, ST_EXEC, B_EXEC);
    for (int i = 0; i < MEM_TIMEOUT - 1; i++)
      push_step(7'b0010010, 1'b0, 1'b0, 1'b1, 1'b0, ST_MEM, B_MEM_ST);
    push_step(7'b0010010, 1'b0, 1'b0, 1'b1, 1'b0, ST_MEM, B_NONE);
    play(-1);
    check_halt(4, 1'b1);

    // halt instruction: retired count is kept, no timeout flag
    do_reset();
    push_instr(K_R, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
    push_instr(K_NOP, 1'b0, 1, 0, 1'b1, 1'b0, 1'b1);
    play(-1);
    check_halt(5, 1'b0);

    // randomized stream; 300 retires wraps the 8-bit counter
    do_reset();
    prev_run = 1'b0;
    for (int n = 0; n < 300; n++) begin
      logic re;
      kind = $urandom_range(0, 6);
      re   = ($urandom_range(0, 3) != 0);
      push_instr(kind, rb(), $urandom_range(0, MEM_TIMEOUT - 1),
                 $urandom_range(0, MEM_TIMEOUT - 1), re, !prev_run, 1'b1);
      prev_run = re;
      play(-1);
    end
    check("rand_retired", 32'(retired), 32'(8'(300)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
